// File: rtl/instr_source_sel.sv
// ---------------------------------------------------------------------------
// instr_source_sel
//
// Instruction-source selector for the single-cycle MIPS fetch path. Routes
// one of NUM_SRC instruction streams to the datapath:
//   source 0        : BIOS ROM
//   source 1        : instruction memory
//   sources 2..N-1  : debug / loader ROMs
//
// Changing the source is a handshaked operation. When the target differs from
// the committed source, the block spends DRAIN cycles driving NOP words. The
// new source then takes over, and switch_ack pulses for one cycle. All state
// updates on the FALLING edge of clock. The reset is asynchronous and
// active-low.
//
// Request handshake
//   switch_req/switch_target are sampled on each falling edge; there is no
//   ready signal. Every sampled request is answered by exactly one of two
//   one-cycle pulses:
//     switch_ack : the request committed, or already matched active_src.
//     switch_err : the request was rejected. This happens when the target
//                  is out of range, a drain is in flight, or the selector is
//                  locked.
//   One exception applies: a request sampled on the same edge where an
//   in-flight drain commits. That edge already carries the ack of the
//   in-flight switch, and ack and err are never raised together. The late
//   request is therefore dropped silently, and the requester sees the ack
//   of the switch in flight.
//
// Parameters
//   WIDTH      instruction width
//   NUM_SRC    number of sources (>= 2)
//   SEL_W      width of a source index
//   DRAIN      NOP cycles inserted on a switch (0..15)
//   NOP        word driven while draining
//   RESET_SRC  source selected out of reset
//
// Ports
//   clock          in   system clock (falling-edge active)
//   reset          in   asynchronous active-low reset
//   src_instr      in   packed sources, source k at [k*WIDTH +: WIDTH]
//   switch_req     in   switch request
//   switch_target  in   requested source index
//   instruction    out  selected instruction (mux after registered state)
//   active_src     out  committed source index
//   switching      out  high while draining
//   switch_ack     out  one-cycle commit pulse
//   switch_err     out  one-cycle reject pulse
//   bios_active    out  source 0 committed and not draining
//   locked         out  selector locked
//
// Optional feature (macro INSTR_SRC_LOCK_EN)
//   Defined   : a commit to source NUM_SRC-1 sets locked. While locked,
//               every request is rejected with switch_err. Only reset
//               clears the lock.
//   Undefined : no lock register is built, and locked is tied low.
// ---------------------------------------------------------------------------
module instr_source_sel #(
    parameter int               WIDTH     = 32,
    parameter int               NUM_SRC   = 2,
    parameter int               SEL_W     = $clog2(NUM_SRC),
    parameter int               DRAIN     = 2,
    parameter logic [WIDTH-1:0] NOP       = '0,
    parameter int               RESET_SRC = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_SRC*WIDTH-1:0] src_instr,
    input  logic                     switch_req,
    input  logic [SEL_W-1:0]         switch_target,
    output logic [WIDTH-1:0]         instruction,
    output logic [SEL_W-1:0]         active_src,
    output logic                     switching,
    output logic                     switch_ack,
    output logic                     switch_err,
    output logic                     bios_active,
    output logic                     locked
);

    // Build-time constants.
    localparam logic [SEL_W-1:0] RESET_SEL   = SEL_W'(RESET_SRC);
    localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_SRC - 1);
    localparam logic [3:0]       DRAIN_LOAD  = (DRAIN > 0) ? 4'(DRAIN - 1) : 4'd0;
    localparam logic [SEL_W:0]   NUM_SRC_EXT = (SEL_W + 1)'(NUM_SRC);

    // FSM state. It is kept as a named enum so checkers can bind to it directly.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // Datapath registers and their next values.
    logic [SEL_W-1:0] active_q;
    logic [SEL_W-1:0] active_next;
    logic [SEL_W-1:0] pending_q;
    logic [SEL_W-1:0] pending_next;
    logic [3:0]       count_q;
    logic [3:0]       count_next;
    logic             ack_q;
    logic             err_q;
    logic             err_next;
    logic             commit;
    logic             lock_q;
    logic             target_valid;

    // The target is compared with one extra bit. This also catches
    // non-power-of-two NUM_SRC, where the index field can encode
    // non-existent sources.
    assign target_valid = ({1'b0, switch_target} < NUM_SRC_EXT);

    // -----------------------------------------------------------------------
    // Lock register (optional)
    // -----------------------------------------------------------------------
`ifdef INSTR_SRC_LOCK_EN
    logic lock_next;

    // The lock is set by any commit that lands on the last source. This
    // includes a same-target ack while the last source is already active.
    always_comb begin
        lock_next = lock_q;
        if (commit && (active_next == LAST_SEL)) begin
            lock_next = 1'b1;
        end
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_next;
        end
    end

    assign locked = lock_q;
`else
    assign lock_q = 1'b0;
    assign locked = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM process 1: state register
    // -----------------------------------------------------------------------
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next-state and datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        active_next  = active_q;
        pending_next = pending_q;
        count_next   = count_q;
        commit       = 1'b0;
        err_next     = 1'b0;

        case (state)
            ST_RUN: begin
                if (switch_req) begin
                    if (lock_q || !target_valid) begin
                        err_next = 1'b1;
                    end else if (switch_target == active_q) begin
                        // Already on the requested source: acknowledge only.
                        commit = 1'b1;
                    end else if (DRAIN == 0) begin
                        active_next = switch_target;
                        commit      = 1'b1;
                    end else begin
                        pending_next = switch_target;
                        count_next   = DRAIN_LOAD;
                        state_next   = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (count_q == 4'd0) begin
                    // Commit edge. A request arriving now is dropped, so that
                    // ack and err are never raised on the same edge.
                    active_next = pending_q;
                    commit      = 1'b1;
                    state_next  = ST_RUN;
                end else begin
                    count_next = count_q - 4'd1;
                    if (switch_req) begin
                        err_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Datapath registers share the FSM clock and reset. A reset during a drain
    // clears everything, so the aborted switch never acknowledges.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            active_q  <= RESET_SEL;
            pending_q <= RESET_SEL;
            count_q   <= 4'd0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            active_q  <= active_next;
            pending_q <= pending_next;
            count_q   <= count_next;
            ack_q     <= commit;
            err_q     <= err_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 3: outputs
    // -----------------------------------------------------------------------
    // The instruction mux follows src_instr with no register in between.
    always_comb begin
        switching   = (state == ST_DRAIN);
        active_src  = active_q;
        switch_ack  = ack_q;
        switch_err  = err_q;
        bios_active = (active_q == '0) && (state != ST_DRAIN);
        if (state == ST_DRAIN) begin
            instruction = NOP;
        end else begin
            instruction = src_instr[int'(active_q) * WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_instr_source_sel.sv
// ---------------------------------------------------------------------------
// tb_instr_source_sel
//
// Testbench for instr_source_sel. Three instances share one clock and one
// reset:
//   u_main  : NUM_SRC=2, DRAIN=2
//   u_zero  : NUM_SRC=2, DRAIN=0
//   u_three : NUM_SRC=3, DRAIN=3
//
// Each table row drives one request into one instance and pushes the expected
// output record. The record is popped and compared after the falling edge.
// Outputs are sampled on the rising edge, half a period from the active
// falling edge. Rows that depend on INSTR_SRC_LOCK_EN take their expectation
// from LK.
// ---------------------------------------------------------------------------
module tb_instr_source_sel;

    localparam logic [31:0] S0    = 32'h2008_0001;
    localparam logic [31:0] S1    = 32'h8C09_0004;
    localparam logic [31:0] S2    = 32'hDEAD_0002;
    localparam logic [31:0] NOP_W = 32'h0000_0000;
`ifdef INSTR_SRC_LOCK_EN
    localparam logic LK = 1'b1;
`else
    localparam logic LK = 1'b0;
`endif

    // Clock and reset.
    logic clock = 1'b1;
    logic reset;
    always #5 clock = ~clock;

    // Stimulus and observed signals.
    logic [63:0] src2;
    logic [95:0] src3;

    logic        req_m;
    logic        tgt_m;
    logic        req_z;
    logic        tgt_z;
    logic        req_t;
    logic [1:0]  tgt_t;

    logic [31:0] instr_m, instr_z, instr_t;
    logic        act_m, act_z;
    logic [1:0]  act_t;
    logic        sw_m, sw_z, sw_t;
    logic        ack_m, ack_z, ack_t;
    logic        err_m, err_z, err_t;
    logic        bios_m, bios_z, bios_t;
    logic        lk_m, lk_z, lk_t;

    instr_source_sel #(.WIDTH(32), .NUM_SRC(2), .DRAIN(2)) u_main (
        .clock(clock), .reset(reset), .src_instr(src2),
        .switch_req(req_m), .switch_target(tgt_m),
        .instruction(instr_m), .active_src(act_m), .switching(sw_m),
        .switch_ack(ack_m), .switch_err(err_m), .bios_active(bios_m),
        .locked(lk_m)
    );

    instr_source_sel #(.WIDTH(32), .NUM_SRC(2), .DRAIN(0)) u_zero (
        .clock(clock), .reset(reset), .src_instr(src2),
        .switch_req(req_z), .switch_target(tgt_z),
        .instruction(instr_z), .active_src(act_z), .switching(sw_z),
        .switch_ack(ack_z), .switch_err(err_z), .bios_active(bios_z),
        .locked(lk_z)
    );

    instr_source_sel #(.WIDTH(32), .NUM_SRC(3), .DRAIN(3)) u_three (
        .clock(clock), .reset(reset), .src_instr(src3),
        .switch_req(req_t), .switch_target(tgt_t),
        .instruction(instr_t), .active_src(act_t), .switching(sw_t),
        .switch_ack(ack_t), .switch_err(err_t), .bios_active(bios_t),
        .locked(lk_t)
    );

    // Scoreboard.
    // Record layout: {instruction, active_src[1:0], switching, ack, err, bios, locked}
    logic [38:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          inst;
        logic        req;
        logic [1:0]  tgt;
        logic [38:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [38:0] mk(logic [31:0] ins, logic [1:0] act, logic sw,
                                       logic ack, logic err, logic bios, logic lk);
        return {ins, act, sw, ack, err, bios, lk};
    endfunction

    function automatic logic [38:0] observe(int inst);
        case (inst)
            0:       return {instr_m, 1'b0, act_m, sw_m, ack_m, err_m, bios_m, lk_m};
            1:       return {instr_z, 1'b0, act_z, sw_z, ack_z, err_z, bios_z, lk_z};
            default: return {instr_t, act_t, sw_t, ack_t, err_t, bios_t, lk_t};
        endcase
    endfunction

    task automatic check(string name, logic [38:0] got, logic [38:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got instr=%h act=%0d sw/ack/err/bios/lk=%b, expected instr=%h act=%0d sw/ack/err/bios/lk=%b",
                     name, got[38:7], got[6:5], got[4:0], exp[38:7], exp[6:5], exp[4:0]);
        end
    endtask

    // Drives one request for one falling edge, then compares against the
    // queued expectation.
    task automatic run_row(int inst, logic req, logic [1:0] tgt, logic [38:0] exp, string name);
        req_m = 1'b0;
        req_z = 1'b0;
        req_t = 1'b0;
        case (inst)
            0:       begin req_m = req; tgt_m = tgt[0]; end
            1:       begin req_z = req; tgt_z = tgt[0]; end
            default: begin req_t = req; tgt_t = tgt;    end
        endcase
        exp_q.push_back(exp);
        @(negedge clock);
        @(posedge clock);
        req_m = 1'b0;
        req_z = 1'b0;
        req_t = 1'b0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard queue empty", name);
        end else begin
            check(name, observe(inst), exp_q.pop_front());
        end
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [38:0] idle0;
        idle0 = mk(S0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        src2  = {S1, S0};
        src3  = {S2, S1, S0};
        req_m = 1'b0; tgt_m = 1'b0;
        req_z = 1'b0; tgt_z = 1'b0;
        req_t = 1'b0; tgt_t = 2'd0;
        reset = 1'b0;

        // Main DRAIN=2 instance: same-target ack, drain, reject during drain.
        vecs.push_back('{0, 1'b0, 2'd0, idle0});
        vecs.push_back('{0, 1'b1, 2'd0, mk(S0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0)});
        vecs.push_back('{0, 1'b1, 2'd1, mk(NOP_W, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)});
        vecs.push_back('{0, 1'b1, 2'd0, mk(NOP_W, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)});
        vecs.push_back('{0, 1'b0, 2'd0, mk(S1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, LK)});
        vecs.push_back('{0, 1'b0, 2'd0, mk(S1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, LK)});
        vecs.push_back('{0, 1'b1, 2'd1, mk(S1, 2'd1, 1'b0, ~LK, LK, 1'b0, LK)});
        vecs.push_back('{0, 1'b1, 2'd0, LK ? mk(S1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1)
                                           : mk(NOP_W, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)});
        vecs.push_back('{0, 1'b0, 2'd0, LK ? mk(S1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)
                                           : mk(NOP_W, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)});
        vecs.push_back('{0, 1'b0, 2'd0, LK ? mk(S1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)
                                           : mk(S0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0)});
        // Zero-drain instance: immediate swap, then same-target request.
        vecs.push_back('{1, 1'b0, 2'd0, idle0});
        vecs.push_back('{1, 1'b1, 2'd1, mk(S1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, LK)});
        vecs.push_back('{1, 1'b1, 2'd1, mk(S1, 2'd1, 1'b0, ~LK, LK, 1'b0, LK)});
        vecs.push_back('{1, 1'b1, 2'd0, LK ? mk(S1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1)
                                           : mk(S0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0)});
        vecs.push_back('{1, 1'b0, 2'd0, LK ? mk(S1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)
                                           : idle0});
        // Three-source instance: out-of-range target, then a 3-cycle drain.
        vecs.push_back('{2, 1'b0, 2'd0, idle0});
        vecs.push_back('{2, 1'b1, 2'd3, mk(S0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)});
        vecs.push_back('{2, 1'b0, 2'd0, idle0});
        vecs.push_back('{2, 1'b1, 2'd2, mk(NOP_W, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)});
        vecs.push_back('{2, 1'b1, 2'd3, mk(NOP_W, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)});
        vecs.push_back('{2, 1'b0, 2'd0, mk(NOP_W, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)});
        vecs.push_back('{2, 1'b0, 2'd0, mk(S2, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, LK)});
        vecs.push_back('{2, 1'b1, 2'd1, LK ? mk(S2, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1)
                                           : mk(NOP_W, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)});

        // Reset state, checked while reset is held and again after release.
        @(posedge clock);
        #1;
        check("reset_main",  observe(0), idle0);
        check("reset_zero",  observe(1), idle0);
        check("reset_three", observe(2), idle0);
        @(posedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(posedge clock);
        check("post_reset_main", observe(0), idle0);

        // The instruction output follows src_instr with zero latency.
        src2[31:0] = 32'h1234_5678;
        #1;
        check("mux_latency", observe(0), mk(32'h1234_5678, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        src2[31:0] = S0;
        #1;
        check("mux_restore", observe(0), idle0);

        // Table-driven vectors.
        foreach (vecs[i]) begin
            run_row(vecs[i].inst, vecs[i].req, vecs[i].tgt, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // A reset pulse clears any lock and in-flight drain on every instance.
        reset = 1'b0;
        #1;
        check("lock_clear_main",  observe(0), idle0);
        check("lock_clear_zero",  observe(1), idle0);
        check("lock_clear_three", observe(2), idle0);
        @(negedge clock);
        @(posedge clock);
        reset = 1'b1;

        // Reset asserted one cycle into a drain aborts it with no ack.
        run_row(0, 1'b1, 2'd1, mk(NOP_W, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "mid_drain_enter");
        run_row(0, 1'b0, 2'd0, mk(NOP_W, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "mid_drain_hold");
        reset = 1'b0;
        #1;
        check("mid_drain_reset", observe(0), idle0);
        @(negedge clock);
        @(posedge clock);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_row(0, 1'b0, 2'd0, idle0, $sformatf("mid_drain_no_ack%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_source_sel.md
# instr_source_sel

Parametrised instruction-source selector for the single-cycle MIPS fetch path. It routes one of `NUM_SRC` instruction streams (source 0 = BIOS ROM, source 1 = instruction memory, further sources = debug/loader ROMs) to the datapath. Source changes go through a handshaked drain sequence that inserts `DRAIN` NOP cycles before the new source takes over. It replaces the fixed two-way BIOS/IM toggle.

## Interface
Parameters:
- `WIDTH`, 32, instruction width in bits
- `NUM_SRC`, 2, number of instruction sources (≥2)
- `SEL_W`, `$clog2(NUM_SRC)`, width of source index
- `DRAIN`, 2, NOP cycles inserted on a switch (0–15)
- `NOP`, 32'h00000000, word driven during drain (`sll $0,$0,0`)
- `RESET_SRC`, 0, source active after reset

Ports:
- `clock`  in  1  system clock; all state updates on its falling edge
- `reset`  in  1  asynchronous, active-low reset
- `src_instr`  in  NUM_SRC*WIDTH  packed sources; source k at bits [k*WIDTH +: WIDTH]
- `switch_req`  in  1  request switch, sampled on falling edge
- `switch_target`  in  SEL_W  requested source index, valid with `switch_req`
- `instruction`  out  WIDTH  selected instruction (combinational from registered state)
- `active_src`  out  SEL_W  currently committed source
- `switching`  out  1  high while in DRAIN
- `switch_ack`  out  1  one-cycle pulse when a switch commits
- `switch_err`  out  1  one-cycle pulse when a request is rejected
- `bios_active`  out  1  `active_src == 0 && !switching`
- `locked`  out  1  lock state (see Configuration)

## Operation
- States: RUN, DRAIN.
- RUN: `instruction = src_instr[active_src]`.
- RUN + `switch_req`, target < NUM_SRC, target ≠ active_src:
  - DRAIN > 0: latch target into `pending_src`, load counter = DRAIN-1, go to DRAIN.
  - DRAIN == 0: commit immediately (`active_src` ← target, `switch_ack` pulse), stay in RUN.
- RUN + `switch_req`, target == active_src: `switch_ack` pulse, no drain, no state change.
- `switch_req` with target ≥ NUM_SRC: `switch_err` pulse, no state change.
- DRAIN: `instruction = NOP`, `switching = 1`, `active_src` still the old source. When counter == 0: `active_src` ← `pending_src`, `switch_ack` pulse, go to RUN. Otherwise decrement.
- `switch_req` during DRAIN: ignored, `switch_err` pulse; the in-flight switch continues unaffected.
- `switch_ack` and `switch_err` are never high on the same edge.

## Timing
- Reset (`reset` low, async): state RUN, `active_src = RESET_SRC`, counter 0, `pending_src = RESET_SRC`, `switching = 0`, `switch_ack = 0`, `switch_err = 0`, `locked = 0`. `instruction = src_instr[RESET_SRC]`, `bios_active = (RESET_SRC == 0)`.
- Reset asserted mid-DRAIN aborts the switch; no ack is issued.
- Request sampled on falling edge N. DRAIN > 0: NOP is driven from edge N through edge N+DRAIN. New source is visible and `switch_ack` is high after edge N+DRAIN, so exactly DRAIN cycles of NOP.
- DRAIN == 0: new source is visible after edge N, with ack on the same edge.
- `switch_ack` and `switch_err` last one full clock period (falling edge to falling edge).
- `instruction` has zero latency from `src_instr` changes (pure mux after state).

## Configuration
- `INSTR_SRC_LOCK_EN` defined: a commit to source `NUM_SRC-1` sets `locked`. While locked, every `switch_req` (including same-target requests) gives a `switch_err` pulse and no change. Only `reset` clears the lock.
- Undefined: no lock logic; `locked` is tied 0; all valid requests are honoured.

## Test plan
- Reset: NUM_SRC=2, hold `reset` low, then release. Expect `active_src=0`, `instruction = src_instr[0]` (e.g. 32'h2008_0001), `bios_active=1`, all pulses 0.
- Basic switch: DRAIN=2, request target 1 at edge N. Expect `instruction = 0` for edges N and N+1. After N+2, expect `src_instr[1]` (32'h8C09_0004), `switch_ack` for one cycle, `bios_active=0`.
- Zero drain plus same-target request: DRAIN=0, request 1 gives an immediate swap with ack. Requesting 1 again gives ack only, no NOP cycle.
- Rejects: NUM_SRC=3, target 3 gives `switch_err` and no change. A request during DRAIN gives `switch_err`, and the original target still commits on schedule.
- Reset mid-drain: assert `reset` one cycle into DRAIN. Expect an immediate return to `RESET_SRC`, `switching=0`, and no ack afterwards.
- Lock (`INSTR_SRC_LOCK_EN`): NUM_SRC=2, switch to 1 sets `locked=1`. A request for 0 then gives `switch_err` and `active_src` stays 1. After reset, `locked=0`.
